// File: rtl/ascii_scan_buffer.sv
// rtl/ascii_scan_buffer.sv - multiplexed ASCII display buffer with cursor, clear FSM and digit scanner
module ascii_scan_buffer #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1024,
    parameter int BLANK    = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         WE,
    input  logic [6:0]                   DIN,
    output logic                         RDY,
    output logic [6:0]                   D,
    output logic [$clog2(DIGITS)-1:0]    SEL,
    output logic [DIGITS-1:0]            DIG,
    output logic [$clog2(DIGITS+1)-1:0]  CUR
);
    localparam int SW = $clog2(DIGITS);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SPACE = 7'h20;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state;
    logic [6:0]    ent [DIGITS];
    logic [SW-1:0] clr_idx;
    logic [PW-1:0] pre;
    logic [SW-1:0] cur_idx;
    logic [SW-1:0] bs_idx;
    logic          printable;
    logic          wrap;

    // CUR only indexes the buffer when it is below DIGITS, so the low bits suffice
    assign cur_idx   = CUR[SW-1:0];
    assign bs_idx    = cur_idx - SW'(1);
    assign printable = (DIN >= 7'h20) && (DIN <= 7'h7E);
    assign wrap      = (pre == PW'(SCAN_DIV - 1));

    assign RDY = (state == IDLE) && !RST;
    assign D   = ent[SEL];
    assign DIG = (pre >= PW'(BLANK)) ? ({{(DIGITS-1){1'b0}}, 1'b1} << SEL) : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DIGITS; i++) ent[i] <= SPACE;
            CUR     <= '0;
            SEL     <= '0;
            pre     <= '0;
            clr_idx <= '0;
            state   <= IDLE;
        end else begin
            pre <= wrap ? '0 : pre + PW'(1);
            if (wrap) SEL <= (SEL == SW'(DIGITS - 1)) ? '0 : SEL + SW'(1);

            case (state)
                IDLE: begin
                    if (WE) begin
                        if (printable) begin
                            if (CUR < CW'(DIGITS)) begin
                                ent[cur_idx] <= DIN;
                                CUR          <= CUR + CW'(1);
                            end else begin
                                // Full line: scroll left and append at the rightmost position
                                for (int i = 0; i < DIGITS - 1; i++) ent[i] <= ent[i+1];
                                ent[DIGITS-1] <= DIN;
                            end
                        end else if (DIN == 7'h08) begin
                            if (CUR != '0) begin
                                CUR         <= CUR - CW'(1);
                                ent[bs_idx] <= SPACE;
                            end
                        end else if (DIN == 7'h0D) begin
                            CUR <= '0;
                        end else if (DIN == 7'h0C) begin
                            clr_idx <= '0;
                            state   <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    ent[clr_idx] <= SPACE;
                    if (clr_idx == SW'(DIGITS - 1)) begin
                        CUR   <= '0;
                        state <= IDLE;
                    end else begin
                        clr_idx <= clr_idx + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascii_scan_buffer.sv
// tb/tb_ascii_scan_buffer.sv - directed and random checks of ascii_scan_buffer against a behavioural model
module tb_ascii_scan_buffer;
    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 16;
    localparam int BLANK    = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WE  = 1'b0;
    logic [6:0] DIN = 7'h00;
    logic       RDY;
    logic [6:0] D;
    logic [2:0] SEL;
    logic [7:0] DIG;
    logic [3:0] CUR;

    int checks   = 0;
    int failures = 0;

    int m_buf [DIGITS];
    int m_cur   = 0;
    int m_t     = 0;
    int m_clr   = 0;
    bit m_valid = 1'b0;

    ascii_scan_buffer #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .DIN(DIN),
        .RDY(RDY), .D(D), .SEL(SEL), .DIG(DIG), .CUR(CUR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input int din);
        if (din >= 32'h20 && din <= 32'h7E) begin
            if (m_cur < DIGITS) begin
                m_buf[m_cur] = din;
                m_cur++;
            end else begin
                for (int i = 0; i < DIGITS - 1; i++) m_buf[i] = m_buf[i+1];
                m_buf[DIGITS-1] = din;
            end
        end else if (din == 32'h08) begin
            if (m_cur > 0) begin
                m_cur--;
                m_buf[m_cur] = 32'h20;
            end
        end else if (din == 32'h0D) begin
            m_cur = 0;
        end else if (din == 32'h0C) begin
            m_clr = DIGITS;
        end
    endtask

    // One clock: drive at the falling edge, check, clock, then advance the model
    task automatic cycle(input bit rst, input bit we, input int din);
        int sel;
        int pre;
        RST = rst;
        WE  = we;
        DIN = din[6:0];
        #1;
        chk("rdy", 32'(RDY), 32'((m_clr == 0) && !rst));
        if (m_valid) begin
            sel = (m_t / SCAN_DIV) % DIGITS;
            pre = m_t % SCAN_DIV;
            chk("cur", 32'(CUR), 32'(m_cur));
            chk("sel", 32'(SEL), 32'(sel));
            chk("d",   32'(D),   32'(m_buf[sel]));
            chk("dig", 32'(DIG), (pre >= BLANK) ? (32'd1 << sel) : 32'd0);
        end
        @(posedge CLK);
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) m_buf[i] = 32'h20;
            m_cur   = 0;
            m_t     = 0;
            m_clr   = 0;
            m_valid = 1'b1;
        end else begin
            m_t++;
            if (m_clr > 0) begin
                m_buf[DIGITS - m_clr] = 32'h20;
                m_clr--;
                if (m_clr == 0) m_cur = 0;
            end else if (we) begin
                model_write(din);
            end
        end
        @(negedge CLK);
    endtask

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) cycle(1'b0, 1'b1, int'(s[i]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
    endtask

    initial begin
        int low;
        int r;
        int din;

        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b1, 32'h41);
        chk("rst_d",   32'(D),   32'h20);
        chk("rst_sel", 32'(SEL), 32'd0);
        chk("rst_dig", 32'(DIG), 32'd0);
        chk("rst_cur", 32'(CUR), 32'd0);

        write_str("HELLO");
        chk("hello_cur", 32'(CUR), 32'd5);
        idle(128);

        cycle(1'b0, 1'b1, 32'h0D);
        write_str("ABCDEFGHI");
        chk("scroll_cur", 32'(CUR), 32'd8);
        idle(128);

        cycle(1'b0, 1'b1, 32'h0D);
        write_str("XYZ");
        cycle(1'b0, 1'b1, 32'h08);
        chk("bs_cur", 32'(CUR), 32'd2);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h08);
        chk("bs_floor", 32'(CUR), 32'd0);

        cycle(1'b0, 1'b1, 32'h0C);
        low = 0;
        for (int i = 0; i < 9; i++) begin
            if (!RDY) low++;
            cycle(1'b0, 1'b1, 32'h41);
        end
        chk("clear_low", 32'(low), 32'd8);
        chk("clear_cur", 32'(CUR), 32'd1);
        idle(128);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      din = $urandom_range(32, 126);
            else if (r < 70) din = 32'h08;
            else if (r < 78) din = 32'h0D;
            else if (r < 81) din = 32'h0C;
            else if (r < 95) din = $urandom_range(0, 31);
            else             din = 32'h7F;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, din);
        end

        write_str("QRS");
        cycle(1'b0, 1'b1, 32'h0C);
        idle(3);
        cycle(1'b1, 1'b0, 0);
        chk("abort_cur", 32'(CUR), 32'd0);
        chk("abort_d",   32'(D),   32'h20);
        cycle(1'b0, 1'b0, 0);
        chk("abort_rdy", 32'(RDY), 32'd1);
        idle(128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ascii_scan_buffer.md
ASCII_SCAN_BUFFER -- requirements
Module: ascii_scan_buffer

Interface
REQ-001 SHALL have parameter DIGITS, default 8, meaning number of display positions (2..16).
REQ-002 SHALL have parameter SCAN_DIV, default 1024, meaning clock cycles per digit slot (>= BLANK+1).
REQ-003 SHALL have parameter BLANK, default 4, meaning dark cycles at the start of each digit slot.
REQ-004 SHALL have port CLK  input  1  system clock, all state on rising edge; the block uses one clock only.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port WE  input  1  write strobe, one character per asserted cycle.
REQ-007 SHALL have port DIN  input  7  ASCII code for the write.
REQ-008 SHALL have port RDY  output  1  block can accept a write this cycle.
REQ-009 SHALL have port D  output  7  ASCII code of the scanned digit; D[0]..D[6] drive decoder D0..D6.
REQ-010 SHALL have port SEL  output  clog2(DIGITS)  index of the scanned digit.
REQ-011 SHALL have port DIG  output  DIGITS  one-hot active-high digit enable, all zero while dark.
REQ-012 SHALL have port CUR  output  clog2(DIGITS+1)  cursor position, 0..DIGITS.

Function
REQ-013 SHALL hold a buffer of DIGITS 7-bit entries; entry 0 is leftmost.
REQ-014 SHALL accept a write only on cycles with WE=1 and RDY=1; WE while RDY=0 SHALL be dropped with no state change.
REQ-015 Printable DIN 0x20..0x7E with CUR<DIGITS: entry[CUR]<=DIN, CUR<=CUR+1.
REQ-016 Printable DIN with CUR=DIGITS: entries shift left one place (entry 0 discarded), entry[DIGITS-1]<=DIN, CUR stays DIGITS, in one cycle.
REQ-017 DIN=0x08 (BS): if CUR>0, CUR<=CUR-1 and entry[CUR-1]<=0x20; if CUR=0, no effect.
REQ-018 DIN=0x0D (CR): CUR<=0, buffer unchanged.
REQ-019 DIN=0x0C (FF): SHALL enter state CLEAR; RDY=0 for exactly DIGITS cycles starting the next cycle; cycle k writes entry[k]<=0x20; on the last cycle CUR<=0 and the state returns to IDLE; RDY=1 the following cycle.
REQ-020 All other DIN (0x00..0x1F except 0x08/0x0C/0x0D, and 0x7F) SHALL be accepted and ignored.
REQ-021 State machine SHALL be IDLE (RDY=1) and CLEAR (RDY=0) only; RDY SHALL equal (state==IDLE).
REQ-022 Prescaler SHALL count 0..SCAN_DIV-1 and wrap continuously, independent of writes and state.
REQ-023 On each prescaler wrap SEL SHALL advance by 1, wrapping DIGITS-1 -> 0.
REQ-024 D SHALL equal entry[SEL] from registered state; a write to entry[SEL] appears on D the cycle after the accepting edge.
REQ-025 DIG SHALL be one-hot at bit SEL when prescaler >= BLANK, else all zero.
REQ-026 Scanning SHALL continue during CLEAR; D shows entries as they are cleared.

Reset
REQ-027 While RST=1 on an edge: all entries<=0x20, CUR<=0, SEL<=0, prescaler<=0, state<=IDLE; RST overrides WE.
REQ-028 RDY SHALL be 0 during cycles with RST=1 and 1 the cycle after reset release.
REQ-029 After reset D=0x20, SEL=0, DIG=0 until prescaler reaches BLANK.
REQ-030 Reset during CLEAR SHALL abort the clear and apply REQ-027 values.

Verification (DIGITS=8, SCAN_DIV=16, BLANK=2)
REQ-031 Reset, write "HELLO" (0x48,0x45,0x4C,0x4C,0x4F) -> entries 0..4 hold those codes, entries 5..7 hold 0x20, CUR=5, RDY constantly 1.
REQ-032 Write 9 chars "ABCDEFGHI" -> entries = "BCDEFGHI", CUR=8.
REQ-033 From CUR=3, write 0x08 -> CUR=2, entry[2]=0x20; four more 0x08 -> CUR=0, no change after reaching 0.
REQ-034 Write 0x0C then hold WE=1 with 0x41 -> RDY=0 for 8 cycles with 0x41 dropped, all entries 0x20, CUR=0; first 0x41 accepted after RDY returns lands in entry 0.
REQ-035 Free-run 128 cycles -> SEL steps 0..7 every 16 cycles; DIG=0 for the first 2 cycles of each slot, then 1<<SEL; D tracks entry[SEL].
REQ-036 Assert RST on the 4th cycle of CLEAR -> next cycle all state at reset values, RDY=1 after release.
